// File: rtl/ed25519_point_unit.sv
`timescale 1ns/1ps
// Edwards25519 extended-coordinate point add / double unit.
// One bit-serial modular multiplier is time-shared under a step sequencer FSM.
module ed25519_point_unit #(
    parameter int           N     = 255,
    parameter logic [N-1:0] P     = 255'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed,
    parameter logic [N-1:0] TWO_D = 255'h2406d9dc_56dffce7_198e80f2_eef3d130_00e0149a_8283b156_ebd69b94_26b2f159
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         mode,
    input  logic [N-1:0] x1, y1, z1, t1,
    input  logic [N-1:0] x2, y2, z2, t2,
    output logic [N-1:0] x3, y3, z3, t3,
    output logic         busy,
    output logic         done
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, COMBINE, DONE} state_t;

    state_t       state;
    logic         mode_r;
    logic [3:0]   k, j, last1, last;
    logic [N-1:0] x1_r, y1_r, z1_r, t1_r, x2_r, y2_r, z2_r, t2_r;
    logic [N-1:0] ra, rb, rc, rd, re, rf, rg, rh;
    logic [N-1:0] op_a, op_b, c_d, c_e, c_f, c_g, c_h;

    logic         mul_en, m_run, m_dr;
    logic [7:0]   m_cnt;
    logic [N-1:0] m_a, m_b, m_acc, m_dbl, m_next;

    function automatic logic [N-1:0] add_modp(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, P}) s = s - {1'b0, P};
        return s[N-1:0];
    endfunction

    // A borrow out of bit N means a < b; adding P back lands in [0, P-1].
    function automatic logic [N-1:0] sub_modp(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (d[N]) d = d + {1'b0, P};
        return d[N-1:0];
    endfunction

    assign last1  = mode_r ? 4'd3 : 4'd4;
    assign last   = mode_r ? 4'd7 : 4'd8;
    assign j      = k - last1 - 4'd1;
    assign mul_en = (state == ISSUE);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        op_a = '0;
        op_b = '0;
        if (k > last1) begin
            case (j)
                4'd0:    begin op_a = re; op_b = rf; end
                4'd1:    begin op_a = rg; op_b = rh; end
                4'd2:    begin op_a = re; op_b = rh; end
                default: begin op_a = rf; op_b = rg; end
            endcase
        end else if (!mode_r) begin
            case (k)
                4'd0:    begin op_a = sub_modp(y1_r, x1_r); op_b = sub_modp(y2_r, x2_r); end
                4'd1:    begin op_a = add_modp(y1_r, x1_r); op_b = add_modp(y2_r, x2_r); end
                4'd2:    begin op_a = t1_r; op_b = t2_r; end
                4'd3:    begin op_a = rc;   op_b = TWO_D; end
                default: begin op_a = z1_r; op_b = z2_r; end
            endcase
        end else begin
            case (k)
                4'd0:    begin op_a = x1_r; op_b = x1_r; end
                4'd1:    begin op_a = y1_r; op_b = y1_r; end
                4'd2:    begin op_a = z1_r; op_b = z1_r; end
                default: begin op_a = add_modp(x1_r, y1_r); op_b = op_a; end
            endcase
        end
    end

    always_comb begin
        c_d = add_modp(rd, rd);
        c_e = '0;
        c_f = '0;
        c_g = '0;
        c_h = '0;
        if (!mode_r) begin
            c_e = sub_modp(rb, ra);
            c_f = sub_modp(c_d, rc);
            c_g = add_modp(c_d, rc);
            c_h = add_modp(rb, ra);
        end else begin
            c_h = add_modp(ra, rb);
            c_e = sub_modp(c_h, rd);
            c_g = sub_modp(ra, rb);
            c_f = add_modp(add_modp(rc, rc), c_g);
        end
    end

    // MSB-first double-and-add; one multiplier bit per cycle.
    assign m_dbl  = add_modp(m_acc, m_acc);
    assign m_next = m_b[N-1] ? add_modp(m_dbl, m_a) : m_dbl;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_run <= 1'b0;
            m_dr  <= 1'b0;
            m_cnt <= '0;
            m_a   <= '0;
            m_b   <= '0;
            m_acc <= '0;
        end else begin
            m_dr <= 1'b0;
            if (mul_en) begin
                m_a   <= op_a;
                m_b   <= op_b;
                m_acc <= '0;
                m_cnt <= 8'(N);
                m_run <= 1'b1;
            end else if (m_run) begin
                m_acc <= m_next;
                m_b   <= {m_b[N-2:0], 1'b0};
                m_cnt <= m_cnt - 8'd1;
                if (m_cnt == 8'd1) begin
                    m_run <= 1'b0;
                    m_dr  <= 1'b1;
                end
            end
        end
    end

    // NOTE: the operand and temporary registers are reset explicitly so a post-reset state is fully defined.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            k      <= '0;
            mode_r <= 1'b0;
            {x1_r, y1_r, z1_r, t1_r, x2_r, y2_r, z2_r, t2_r} <= '0;
            {ra, rb, rc, rd, re, rf, rg, rh} <= '0;
            {x3, y3, z3, t3} <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (start) begin
                        mode_r <= mode;
                        {x1_r, y1_r, z1_r, t1_r} <= {x1, y1, z1, t1};
                        {x2_r, y2_r, z2_r, t2_r} <= {x2, y2, z2, t2};
                        k     <= '0;
                        busy  <= 1'b1;
                        state <= ISSUE;
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (m_dr) begin
                        if (k > last1) begin
                            case (j)
                                4'd0:    ra <= m_acc;
                                4'd1:    rb <= m_acc;
                                4'd2:    rc <= m_acc;
                                default: begin
                                    x3 <= ra;
                                    y3 <= rb;
                                    t3 <= rc;
                                    z3 <= m_acc;
                                end
                            endcase
                        end else begin
                            case (k)
                                4'd0:    ra <= m_acc;
                                4'd1:    rb <= m_acc;
                                4'd2:    rc <= m_acc;
                                4'd3:    if (mode_r) rd <= m_acc; else rc <= m_acc;
                                default: rd <= m_acc;
                            endcase
                        end
                        if (k == last) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else if (k == last1) begin
                            state <= COMBINE;
                        end else begin
                            k     <= k + 4'd1;
                            state <= ISSUE;
                        end
                    end
                end
                COMBINE: begin
                    re    <= c_e;
                    rf    <= c_f;
                    rg    <= c_g;
                    rh    <= c_h;
                    k     <= k + 4'd1;
                    state <= ISSUE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ed25519_point_unit.sv
`timescale 1ns/1ps
// Self-checking bench for ed25519_point_unit: directed and random operations
// compared against a big-integer reference of the Edwards25519 formulas.
module tb_ed25519_point_unit;
    localparam int N = 255;
    localparam logic [N-1:0] P     = 255'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;
    localparam logic [N-1:0] TWO_D = 255'h2406d9dc_56dffce7_198e80f2_eef3d130_00e0149a_8283b156_ebd69b94_26b2f159;
    // Multiplier latency L of this unit: one cycle per operand bit plus the result cycle.
    localparam int MUL_LAT = 256;
    localparam int ADD_LAT = 9 * (MUL_LAT + 1) + 2;
    localparam int DBL_LAT = 8 * (MUL_LAT + 1) + 2;

    typedef logic [N-1:0] fe_t;
    typedef struct packed { fe_t x; fe_t y; fe_t z; fe_t t; } pt_t;

    logic clk = 1'b0;
    logic rst, start, mode, busy, done;
    fe_t  x1, y1, z1, t1, x2, y2, z2, t2, x3, y3, z3, t3;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    ed25519_point_unit dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .x1(x1), .y1(y1), .z1(z1), .t1(t1),
        .x2(x2), .y2(y2), .z2(z2), .t2(t2),
        .x3(x3), .y3(y3), .z3(z3), .t3(t3),
        .busy(busy), .done(done)
    );

    function automatic fe_t addm(input fe_t a, input fe_t b);
        return fe_t'(({1'b0, a} + {1'b0, b}) % {1'b0, P});
    endfunction

    function automatic fe_t subm(input fe_t a, input fe_t b);
        return fe_t'(({1'b0, a} + {1'b0, P} - {1'b0, b}) % {1'b0, P});
    endfunction

    function automatic fe_t mulm(input fe_t a, input fe_t b);
        logic [2*N-1:0] pr;
        pr = {{N{1'b0}}, a} * {{N{1'b0}}, b};
        return fe_t'(pr % {{N{1'b0}}, P});
    endfunction

    function automatic fe_t rand_fe();
        logic [N:0] w;
        for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
        return fe_t'(w % {1'b0, P});
    endfunction

    function automatic pt_t rand_pt();
        pt_t r;
        r.x = rand_fe(); r.y = rand_fe(); r.z = rand_fe(); r.t = rand_fe();
        return r;
    endfunction

    // Reference: extended twisted-Edwards (a = -1) unified addition and doubling.
    function automatic pt_t ref_op(input logic m, input pt_t a, input pt_t b);
        fe_t ea, eb, ec, ed, e, f, g, h;
        pt_t r;
        if (!m) begin
            ea = mulm(subm(a.y, a.x), subm(b.y, b.x));
            eb = mulm(addm(a.y, a.x), addm(b.y, b.x));
            ec = mulm(mulm(a.t, b.t), TWO_D);
            ed = addm(mulm(a.z, b.z), mulm(a.z, b.z));
            e = subm(eb, ea); f = subm(ed, ec); g = addm(ed, ec); h = addm(eb, ea);
        end else begin
            ea = mulm(a.x, a.x);
            eb = mulm(a.y, a.y);
            ec = addm(mulm(a.z, a.z), mulm(a.z, a.z));
            h = addm(ea, eb);
            e = subm(h, mulm(addm(a.x, a.y), addm(a.x, a.y)));
            g = subm(ea, eb);
            f = addm(ec, g);
        end
        r.x = mulm(e, f); r.y = mulm(g, h); r.t = mulm(e, h); r.z = mulm(f, g);
        return r;
    endfunction

    function automatic pt_t out_pt();
        pt_t r;
        r.x = x3; r.y = y3; r.z = z3; r.t = t3;
        return r;
    endfunction

    task automatic check(input string tag, input fe_t obs, input fe_t exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_pt(input string tag, input pt_t obs, input pt_t exp);
        check({tag, "_x"}, obs.x, exp.x);
        check({tag, "_y"}, obs.y, exp.y);
        check({tag, "_z"}, obs.z, exp.z);
        check({tag, "_t"}, obs.t, exp.t);
    endtask

    // Call on a negedge; the following posedge samples the request.
    task automatic launch(input logic m, input pt_t a, input pt_t b);
        mode = m;
        x1 = a.x; y1 = a.y; z1 = a.z; t1 = a.t;
        x2 = b.x; y2 = b.y; z2 = b.z; t2 = b.t;
        start = 1'b1;
    endtask

    // Returns on the negedge where done is seen; lat counts cycles after the accepting edge.
    task automatic wait_done(input string tag, output int lat, output int bcnt);
        bit ok;
        lat = 0; bcnt = 0; ok = 1'b0;
        for (int i = 0; i < ADD_LAT + 50; i++) begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (done) begin ok = 1'b1; break; end
            if (busy) bcnt++;
        end
        check({tag, "_done_seen"}, fe_t'(ok), fe_t'(1));
    endtask

    initial begin
        #800_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        pt_t id, bp, ra, pa, pb, exp_pt, w1, w2;
        int  lat, bc, dcnt;

        rst = 1'b1; start = 1'b0; mode = 1'b0;
        {x1, y1, z1, t1, x2, y2, z2, t2} = '0;
        id.x = '0; id.y = fe_t'(1); id.z = fe_t'(1); id.t = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", fe_t'(busy), '0);
        check("rst_done", fe_t'(done), '0);
        check_pt("rst_out", out_pt(), '0);
        rst = 1'b0;
        @(negedge clk);

        // Identity + identity.
        launch(1'b0, id, id);
        wait_done("id_add", lat, bc);
        check("id_add_lat", fe_t'(lat), fe_t'(ADD_LAT));
        check("id_add_busy_cycles", fe_t'(bc), fe_t'(ADD_LAT - 1));
        exp_pt.x = '0; exp_pt.y = fe_t'(4); exp_pt.z = fe_t'(4); exp_pt.t = '0;
        check_pt("id_add", out_pt(), exp_pt);
        @(negedge clk);
        check("id_add_done_one_cycle", fe_t'(done), '0);
        check("id_add_idle_busy", fe_t'(busy), '0);

        // Identity doubling.
        launch(1'b1, id, rand_pt());
        wait_done("id_dbl", lat, bc);
        check("id_dbl_lat", fe_t'(lat), fe_t'(DBL_LAT));
        exp_pt.x = '0; exp_pt.y = P - 1; exp_pt.z = P - 1; exp_pt.t = '0;
        check_pt("id_dbl", out_pt(), exp_pt);
        @(negedge clk);

        // Base point: add(B,B) then dbl(B) issued in the DONE cycle.
        bp.x = 255'h216936d3_cd6e53fe_c0a4e231_fdd6dc5c_692cc760_9525a7b2_c9562d60_8f25d51a;
        bp.y = 255'h66666666_66666666_66666666_66666666_66666666_66666666_66666666_66666658;
        bp.z = fe_t'(1);
        bp.t = mulm(bp.x, bp.y);
        launch(1'b0, bp, bp);
        wait_done("b_add", lat, bc);
        ra = out_pt();
        check_pt("b_add", ra, ref_op(1'b0, bp, bp));
        launch(1'b1, bp, rand_pt());
        wait_done("b_dbl", lat, bc);
        check("b_dbl_lat_from_done", fe_t'(lat), fe_t'(DBL_LAT));
        check_pt("b_dbl", out_pt(), ref_op(1'b1, bp, bp));
        check("b_affine_x", mulm(ra.x, z3), mulm(x3, ra.z));
        check("b_affine_y", mulm(ra.y, z3), mulm(y3, ra.z));
        @(negedge clk);

        // A second start during WAIT must be ignored.
        pa = rand_pt(); pb = rand_pt();
        exp_pt = ref_op(1'b0, pa, pb);
        launch(1'b0, pa, pb);
        @(negedge clk);
        start = 1'b0;
        repeat (299) @(negedge clk);
        launch(1'b1, rand_pt(), rand_pt());
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_start", lat, bc);
        check("busy_start_lat", fe_t'(lat + 301), fe_t'(ADD_LAT));
        check_pt("busy_start", out_pt(), exp_pt);
        dcnt = 0;
        for (int i = 0; i < ADD_LAT + 20; i++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("busy_start_extra_done", fe_t'(dcnt), '0);

        // Reset in phase 2 aborts; the next operation runs cleanly.
        launch(1'b0, bp, bp);
        @(negedge clk);
        start = 1'b0;
        repeat (1499) @(negedge clk);
        check("mid_busy_before_rst", fe_t'(busy), fe_t'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", fe_t'(busy), '0);
        check("mid_rst_done", fe_t'(done), '0);
        check_pt("mid_rst_out", out_pt(), '0);
        launch(1'b0, id, id);
        wait_done("post_rst", lat, bc);
        check("post_rst_lat", fe_t'(lat), fe_t'(ADD_LAT));
        exp_pt.x = '0; exp_pt.y = fe_t'(4); exp_pt.z = fe_t'(4); exp_pt.t = '0;
        check_pt("post_rst", out_pt(), exp_pt);
        @(negedge clk);

        // (-1,0) + (1,0): y - x underflows; affine result (0,-1).
        w1.x = P - 1; w1.y = '0; w1.z = fe_t'(1); w1.t = '0;
        w2.x = fe_t'(1); w2.y = '0; w2.z = fe_t'(1); w2.t = '0;
        launch(1'b0, w1, w2);
        wait_done("wrap", lat, bc);
        exp_pt.x = '0; exp_pt.y = P - 4; exp_pt.z = fe_t'(4); exp_pt.t = '0;
        check_pt("wrap", out_pt(), exp_pt);
        check_pt("wrap_ref", out_pt(), ref_op(1'b0, w1, w2));
        @(negedge clk);

        // Random field elements through both modes.
        pa = rand_pt(); pb = rand_pt();
        launch(1'b0, pa, pb);
        wait_done("rnd_add", lat, bc);
        check_pt("rnd_add", out_pt(), ref_op(1'b0, pa, pb));
        @(negedge clk);
        pa = rand_pt();
        launch(1'b1, pa, rand_pt());
        wait_done("rnd_dbl", lat, bc);
        check_pt("rnd_dbl", out_pt(), ref_op(1'b1, pa, pa));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
